// File: rtl/count_pkg.sv
// Shared types and default widths for the counter
// sequencer, its counter and the bench.
package count_pkg;

  localparam int W     = 5;
  localparam int REP_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE,
    ABORT
  } state_t;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Control-side bundle of the counter sequencer:
// run request, operands and run status.
interface count_seq_ctrl_if
  import count_pkg::*;
#(
  parameter int W     = count_pkg::W,
  parameter int REP_W = count_pkg::REP_W
);

  logic             start;
  logic             stop;
  logic [W-1:0]     limit;
  logic [REP_W-1:0] reps;
  logic             busy;
  logic [REP_W-1:0] pass_cnt;
  logic             done;
  logic             aborted;

  modport master (
    output start,
    output stop,
    output limit,
    output reps,
    input  busy,
    input  pass_cnt,
    input  done,
    input  aborted
  );

  modport slave (
    input  start,
    input  stop,
    input  limit,
    input  reps,
    output busy,
    output pass_cnt,
    output done,
    output aborted
  );

endinterface

// File: rtl/count_seq_ctrl.sv
// Runs an external enable/clear counter from 0 to a
// latched limit for a latched number of passes.
module count_seq_ctrl
  import count_pkg::*;
#(
  parameter int W     = count_pkg::W,
  parameter int REP_W = count_pkg::REP_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  count_seq_ctrl_if.slave ctrl,
  input  logic [W-1:0]    i_cnt_in,
  output logic            o_cnt_clr,
  output logic            o_cnt_en
);

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_limit;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_pass;
  logic [REP_W-1:0] w_pass_nx;
  logic             w_accept;
  logic             w_inc;
  logic             w_term;

  // >= rather than == so a stray value past the limit still ends the pass
  assign w_term    = (i_cnt_in >= r_limit);
  assign w_pass_nx = r_pass + 1'b1;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_inc    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ctrl.start && !ctrl.stop) begin
          w_accept = 1'b1;
          w_next   = (ctrl.reps == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        w_next = ctrl.stop ? ABORT : RUN;
      end
      RUN: begin
        if (ctrl.stop) begin
          w_next = ABORT;
        end else if (w_term) begin
          w_inc  = 1'b1;
          w_next = (w_pass_nx == r_reps) ? DONE : CLEAR;
        end
      end
      DONE, ABORT: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_limit <= '0;
      r_reps  <= '0;
      r_pass  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_limit <= ctrl.limit;
        r_reps  <= ctrl.reps;
        r_pass  <= '0;
      end else if (w_inc) begin
        r_pass  <= w_pass_nx;
      end
    end
  end

  assign o_cnt_clr = (r_state == CLEAR);
  assign o_cnt_en  = (r_state == RUN) && (i_cnt_in < r_limit)
                     && !ctrl.stop;

  assign ctrl.busy     = (r_state == CLEAR) || (r_state == RUN);
  assign ctrl.pass_cnt = r_pass;
  assign ctrl.done     = (r_state == DONE);
  assign ctrl.aborted  = (r_state == ABORT);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl with a counter in the loop and a
// timeline-based reference model of each run.
module tb_count_seq_ctrl;
  import count_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cnt;
  logic         clr;
  logic         en;

  always #10 clk = ~clk;

  count_seq_ctrl_if cif ();

  count_seq_ctrl dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .ctrl     (cif),
    .i_cnt_in (cnt),
    .o_cnt_clr(clr),
    .o_cnt_en (en)
  );

  // the counter being sequenced
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               n, a, e, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: a run is a timeline of R periods of (L+2) cycles,
  // one clear cycle then L+1 run cycles; t counts from 1.
  bit m_act   = 1'b0;
  int m_t     = 0;
  int m_L     = 0;
  int m_R     = 0;
  int m_hold  = 0;
  int m_pulse = 0;

  always @(posedge clk) begin
    int p;
    p = m_L + 2;
    if (rst) begin
      m_act   = 1'b0;
      m_pulse = 0;
      m_hold  = 0;
    end else if (m_act) begin
      if (cif.stop) begin
        m_act   = 1'b0;
        m_pulse = 2;
        m_hold  = (m_t - 1) / p;
      end else if (m_t == m_R * p) begin
        m_act   = 1'b0;
        m_pulse = 1;
        m_hold  = m_R;
      end else begin
        m_t++;
      end
    end else if (m_pulse != 0) begin
      m_pulse = 0;
    end else if (cif.start && !cif.stop) begin
      m_L    = int'(cif.limit);
      m_R    = int'(cif.reps);
      m_hold = 0;
      if (m_R == 0) m_pulse = 1;
      else begin
        m_act = 1'b1;
        m_t   = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int p, o, e_pass;
      bit e_clr, e_en, e_busy, c_chk;
      int e_k;
      p      = m_L + 2;
      e_clr  = 1'b0;
      e_en   = 1'b0;
      e_busy = 1'b0;
      c_chk  = 1'b0;
      e_k    = 0;
      e_pass = m_hold;
      if (m_act) begin
        o      = (m_t - 1) % p;
        e_busy = 1'b1;
        e_pass = (m_t - 1) / p;
        if (o == 0) e_clr = 1'b1;
        else begin
          e_k   = o - 1;
          c_chk = 1'b1;
          e_en  = (e_k < m_L) && !cif.stop;
        end
      end
      chk("cnt_clr", 32'(clr), 32'(e_clr));
      chk("cnt_en", 32'(en), 32'(e_en));
      chk("busy", 32'(cif.busy), 32'(e_busy));
      chk("done", 32'(cif.done), 32'(m_pulse == 1));
      chk("aborted", 32'(cif.aborted), 32'(m_pulse == 2));
      chk("pass_cnt", 32'(cif.pass_cnt), 32'(e_pass));
      if (c_chk) chk("cnt_in", 32'(cnt), 32'(e_k));
    end
  end

  task automatic run(input int L, input int R,
                     input int stop_at, input int bstart_at,
                     output int dlat, output int alat,
                     output int n_en, output int n_clr,
                     output int c1, output int c2,
                     output int en_stop, output int p_end,
                     output int c_end);
    cif.limit = W'(L);
    cif.reps  = REP_W'(R);
    cif.start = 1'b1;
    cif.stop  = 1'b0;
    tick;
    cif.start = 1'b0;
    dlat = -1; alat = -1; n_en = 0; n_clr = 0;
    c1 = -1; c2 = -1; en_stop = -1; p_end = -1; c_end = -1;
    for (int t = 1; t <= 200; t++) begin
      cif.stop  = (t == stop_at);
      cif.start = (t == bstart_at);
      cif.limit = W'($urandom);
      cif.reps  = REP_W'($urandom);
      @(negedge clk);
      if (en) n_en++;
      if (clr) begin
        n_clr++;
        if (c1 < 0) c1 = t;
        else if (c2 < 0) c2 = t;
      end
      if (t == stop_at) en_stop = int'(en);
      if (cif.done || cif.aborted) begin
        if (cif.done) dlat = t;
        else alat = t;
        p_end = int'(cif.pass_cnt);
        c_end = int'(cnt);
        break;
      end
      tick;
    end
    tick;
    cif.start = 1'b0;
    cif.stop  = 1'b0;
  endtask

  initial begin
    int dl, al, ne, nc, c1, c2, es, pe, ce, pulses;
    rst       = 1'b1;
    cif.start = 1'b0;
    cif.stop  = 1'b0;
    cif.limit = '0;
    cif.reps  = '0;
    tick;
    tick;
    chk_on = 1'b1;
    rst    = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(cif.busy), 0);
    chk("rst_done", 32'(cif.done | cif.aborted), 0);
    chk("rst_clr_en", 32'(clr | en), 0);
    chk("rst_pass", 32'(cif.pass_cnt), 0);
    tick;

    run(3, 2, -1, -1, dl, al, ne, nc, c1, c2, es, pe, ce);
    chk("t2_done_cyc", dl, 11);
    chk("t2_en_cycles", ne, 6);
    chk("t2_clr_n", nc, 2);
    chk("t2_clr1", c1, 1);
    chk("t2_clr2", c2, 6);
    chk("t2_pass", pe, 2);
    chk("t2_cnt_end", ce, 3);

    run(0, 3, -1, -1, dl, al, ne, nc, c1, c2, es, pe, ce);
    chk("t3_done_cyc", dl, 7);
    chk("t3_en_cycles", ne, 0);

    run(7, 0, -1, -1, dl, al, ne, nc, c1, c2, es, pe, ce);
    chk("t3r0_done_cyc", dl, 1);
    chk("t3r0_clr_n", nc, 0);
    chk("t3r0_pass", pe, 0);

    run(31, 1, -1, -1, dl, al, ne, nc, c1, c2, es, pe, ce);
    chk("t4_done_cyc", dl, 34);
    chk("t4_en_cycles", ne, 31);
    chk("t4_cnt_end", ce, 31);

    run(5, 3, 11, -1, dl, al, ne, nc, c1, c2, es, pe, ce);
    chk("t5_en_at_stop", es, 0);
    chk("t5_abort_cyc", al, 12);
    chk("t5_no_done", dl, -1);
    chk("t5_pass", pe, 1);

    cif.limit = 5'd2;
    cif.reps  = 4'd1;
    cif.start = 1'b1;
    cif.stop  = 1'b1;
    tick;
    cif.start = 1'b0;
    cif.stop  = 1'b0;
    @(negedge clk);
    chk("t5_ss_busy", 32'(cif.busy), 0);
    chk("t5_ss_clr", 32'(clr), 0);
    tick;

    run(4, 2, -1, 3, dl, al, ne, nc, c1, c2, es, pe, ce);
    chk("t6_busy_start", dl, 13);

    cif.limit = 5'd10;
    cif.reps  = 4'd2;
    cif.start = 1'b1;
    tick;
    cif.start = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cif.done || cif.aborted || cif.busy || clr || en)
        pulses++;
      tick;
    end
    chk("t6_rst_quiet", pulses, 0);

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cif.start = ($urandom_range(0, 3) == 0);
      cif.stop  = ($urandom_range(0, 39) == 0);
      cif.limit = ($urandom_range(0, 9) == 0) ? 5'd31
                  : W'($urandom_range(0, 6));
      cif.reps  = REP_W'($urandom_range(0, 3));
      tick;
    end
    rst       = 1'b0;
    cif.start = 1'b0;
    cif.stop  = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
